// File: rtl/instr_loader.sv
// Boot-time program loader: assembles little-endian bytes into 32-bit words,
// writes them to instruction memory and stalls the core for the whole load.
module instr_loader #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-3:0] len_words,
  input  logic                  abort,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  trigger,
  output logic                  done
);

  localparam int WW = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

  state_t                state, state_nx;
  logic [1:0]            byte_cnt, byte_cnt_nx;
  logic [WW-1:0]         word_cnt, word_cnt_nx, word_inc;
  logic [WW-1:0]         len_q, len_nx;
  logic [23:0]           asm_q, asm_nx;
  logic                  we_nx, done_nx, trigger_nx, ready_nx;
  logic [ADDR_WIDTH-1:0] addr_nx;
  logic [31:0]           wdata_nx;
  logic                  accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      word_cnt   <= '0;
      len_q      <= '0;
      asm_q      <= '0;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      trigger    <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      byte_cnt   <= byte_cnt_nx;
      word_cnt   <= word_cnt_nx;
      len_q      <= len_nx;
      asm_q      <= asm_nx;
      byte_ready <= ready_nx;
      imem_we    <= we_nx;
      imem_addr  <= addr_nx;
      imem_wdata <= wdata_nx;
      trigger    <= trigger_nx;
      done       <= done_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    byte_cnt_nx = byte_cnt;
    word_cnt_nx = word_cnt;
    len_nx      = len_q;
    asm_nx      = asm_q;
    we_nx       = 1'b0;
    done_nx     = 1'b0;
    addr_nx     = imem_addr;
    wdata_nx    = imem_wdata;
    word_inc    = word_cnt + 1'b1;
    accept      = byte_valid && byte_ready && (state == LOAD);

    unique case (state)
      IDLE: begin
        if (start) begin
          if (len_words != '0) begin
            len_nx      = len_words;
            byte_cnt_nx = '0;
            word_cnt_nx = '0;
            state_nx    = LOAD;
          end else begin
            done_nx = 1'b1;
          end
        end
      end
      LOAD: begin
        // abort takes priority even over a word-completing byte
        if (abort) begin
          state_nx = IDLE;
        end else if (accept) begin
          byte_cnt_nx = byte_cnt + 2'd1;
          unique case (byte_cnt)
            2'd0: asm_nx[7:0]   = byte_data;
            2'd1: asm_nx[15:8]  = byte_data;
            2'd2: asm_nx[23:16] = byte_data;
            2'd3: begin
              we_nx       = 1'b1;
              addr_nx     = {word_cnt, 2'b00};
              wdata_nx    = {byte_data, asm_q};
              word_cnt_nx = word_inc;
              if (word_inc == len_q) state_nx = FLUSH;
            end
          endcase
        end
      end
      FLUSH: begin
        state_nx = IDLE;
        done_nx  = 1'b1;
      end
      default: state_nx = IDLE;
    endcase

    trigger_nx = (state_nx != IDLE);
    ready_nx   = (state_nx == LOAD);
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: fixed vector table, directed corner
// sequences and randomized loads checked against a transaction-level model.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  len_words;
  logic        abort;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [11:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        trigger;
  logic        done;

  int checks = 0;
  int failures = 0;

  logic [11:0] exp_addr;
  logic [31:0] exp_wdata;

  instr_loader #(.ADDR_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .start(start), .len_words(len_words), .abort(abort),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .trigger(trigger), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic ready, input logic we,
                         input logic [11:0] addr, input logic [31:0] wdata,
                         input logic trig, input logic dn);
    chk({tag, ".byte_ready"}, 32'(byte_ready), 32'(ready));
    chk({tag, ".imem_we"},    32'(imem_we),    32'(we));
    chk({tag, ".imem_addr"},  32'(imem_addr),  32'(addr));
    chk({tag, ".imem_wdata"}, imem_wdata,      wdata);
    chk({tag, ".trigger"},    32'(trigger),    32'(trig));
    chk({tag, ".done"},       32'(done),       32'(dn));
  endtask

  typedef struct {
    logic        start;
    logic [9:0]  len;
    logic        bv;
    logic [7:0]  bd;
    logic        ready;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        trig;
    logic        done;
  } vec_t;

  vec_t vecs[13];

  // One load transaction. Expected writes come from the byte list: every 4th
  // accepted byte produces word acc/4-1 at byte address 4*(acc/4-1).
  // mode: 0 = byte every cycle, 1 = every other cycle, 2 = random 60%.
  task automatic run_load(input int len, input int mode, input int abort_at, input int restart_at);
    logic [7:0] bytes[$];
    int acc = 0;
    int cyc = 0;
    bit aborted = 0;
    bit bv;
    logic exp_we;
    for (int i = 0; i < 4 * len; i++) bytes.push_back(8'($urandom_range(0, 255)));

    @(negedge clk);
    start = 1'b1; len_words = 10'(len); byte_valid = 1'b0; abort = 1'b0;
    tick();
    chk("ld.start.trigger", 32'(trigger), 32'd1);
    chk("ld.start.ready",   32'(byte_ready), 32'd1);
    chk("ld.start.we",      32'(imem_we), 32'd0);

    while (acc < 4 * len && !aborted && cyc < 2000) begin
      @(negedge clk);
      bv = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : ($urandom_range(0, 99) < 60);
      byte_valid = bv;
      byte_data  = bv ? bytes[acc] : 8'($urandom);
      abort      = bv && (acc == abort_at);
      start      = (cyc == restart_at);
      len_words  = 10'($urandom);
      tick();
      exp_we = 1'b0;
      if (abort) aborted = 1;
      else if (bv) begin
        acc++;
        if (acc % 4 == 0) begin
          exp_we    = 1'b1;
          exp_addr  = 12'((acc / 4 - 1) * 4);
          exp_wdata = {bytes[acc-1], bytes[acc-2], bytes[acc-3], bytes[acc-4]};
        end
      end
      chk("ld.imem_we",    32'(imem_we),    32'(exp_we));
      chk("ld.imem_addr",  32'(imem_addr),  32'(exp_addr));
      chk("ld.imem_wdata", imem_wdata,      exp_wdata);
      chk("ld.trigger",    32'(trigger),    32'(!aborted));
      chk("ld.byte_ready", 32'(byte_ready), 32'(!aborted && acc < 4 * len));
      chk("ld.done",       32'(done),       32'd0);
      cyc++;
    end
    if (cyc >= 2000) chk("ld.timeout", 32'(cyc), 32'd0);

    @(negedge clk);
    start = 1'b0; abort = 1'b0; byte_valid = 1'b0;
    tick();
    chk("ld.end.done",    32'(done),    32'(!aborted));
    chk("ld.end.trigger", 32'(trigger), 32'd0);
    chk("ld.end.we",      32'(imem_we), 32'd0);
    chk("ld.end.ready",   32'(byte_ready), 32'd0);
    tick();
    chk("ld.after.done",  32'(done),    32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len_words = '0; abort = 1'b0;
    byte_valid = 1'b0; byte_data = '0;
    repeat (2) tick();
    chk_all("reset", 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    vecs[0]  = '{1'b1, 10'd2, 1'b0, 8'h00, 1'b1, 1'b0, 12'h000, 32'h00000000, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 10'd0, 1'b1, 8'h13, 1'b1, 1'b0, 12'h000, 32'h00000000, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 10'd0, 1'b1, 8'h00, 1'b1, 1'b0, 12'h000, 32'h00000000, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 10'd0, 1'b1, 8'h50, 1'b1, 1'b0, 12'h000, 32'h00000000, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 10'd0, 1'b1, 8'h00, 1'b1, 1'b1, 12'h000, 32'h00500013, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 10'd0, 1'b1, 8'h93, 1'b1, 1'b0, 12'h000, 32'h00500013, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 10'd0, 1'b1, 8'h00, 1'b1, 1'b0, 12'h000, 32'h00500013, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 10'd0, 1'b1, 8'hA0, 1'b1, 1'b0, 12'h000, 32'h00500013, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 10'd0, 1'b1, 8'h00, 1'b0, 1'b1, 12'h004, 32'h00A00093, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 10'd0, 1'b0, 8'h00, 1'b0, 1'b0, 12'h004, 32'h00A00093, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 10'd0, 1'b0, 8'h00, 1'b0, 1'b0, 12'h004, 32'h00A00093, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 10'd0, 1'b0, 8'h00, 1'b0, 1'b0, 12'h004, 32'h00A00093, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 10'd0, 1'b0, 8'h00, 1'b0, 1'b0, 12'h004, 32'h00A00093, 1'b0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      start = vecs[i].start; len_words = vecs[i].len;
      byte_valid = vecs[i].bv; byte_data = vecs[i].bd;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].ready, vecs[i].we, vecs[i].addr,
              vecs[i].wdata, vecs[i].trig, vecs[i].done);
    end
    exp_addr = 12'h004;
    exp_wdata = 32'h00A00093;

    // rst after two bytes of word 0: everything back to reset values, no write
    @(negedge clk);
    start = 1'b1; len_words = 10'd2; byte_valid = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start = 1'b0; byte_valid = 1'b1; byte_data = 8'(8'h11 * (i + 1));
      tick();
    end
    @(negedge clk);
    rst = 1'b1; byte_data = 8'h77;
    tick();
    chk_all("rst_mid", 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0; byte_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("rst_idle", 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0);
    end
    exp_addr = '0;
    exp_wdata = '0;

    run_load(1, 1, -1, -1);
    run_load(3, 0, 5, -1);
    run_load(2, 0, -1, -1);
    run_load(4, 2, -1, 3);

    for (int n = 0; n < 25; n++) begin
      int len = $urandom_range(1, 8);
      int ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4 * len - 1) : -1;
      int rs = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 20) : -1;
      run_load(len, $urandom_range(0, 2), ab, rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Boot-time program loader that writes instruction memory from a byte stream, one 32-bit word at a time.
- Holds the control unit's stall input (trigger) high for the whole load, so the core keeps PC and suppresses all register/memory writes.
- Sits between an external byte source (UART receiver, testbench or debug port) and the instruction memory's write port.
- Releases the core once the last word is committed.

Parameters:
ADDR_WIDTH, 12, byte-address width of instruction memory write port (capacity 2^(ADDR_WIDTH-2) words)

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous active-high reset
start  input  1  begin load; sampled only in IDLE
len_words  input  ADDR_WIDTH-2  number of words to load; latched on accepted start
abort  input  1  cancel load in progress
byte_valid  input  1  byte_data is valid this cycle
byte_data  input  8  next program byte, little-endian within each word
byte_ready  output  1  loader accepts a byte this cycle
imem_we  output  1  instruction memory write enable, one-cycle pulse per word
imem_addr  output  ADDR_WIDTH  byte address of the word being written (word-aligned)
imem_wdata  output  32  assembled instruction word
trigger  output  1  stall request to control unit; high while loading
done  output  1  one-cycle pulse when a load completes normally

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- All outputs are registered.
- Reset values:
  - state=IDLE; trigger=0, byte_ready=0, imem_we=0, done=0.
  - imem_addr=0, imem_wdata=0.
  - Internal byte_cnt=0, word_cnt=0.
  - rst mid-load discards the partial word and issues no write or done.
- States: IDLE, LOAD, FLUSH.
- IDLE:
  - byte_ready=0, trigger=0.
  - start=1 with len_words!=0: latch len, clear byte_cnt and word_cnt, go to LOAD. trigger and byte_ready rise the next cycle.
  - start=1 with len_words==0: stay IDLE, pulse done the next cycle, no trigger.
- LOAD:
  - trigger=1, byte_ready=1.
  - Byte accept = byte_valid & byte_ready.
  - Accepted byte k (k=byte_cnt) goes to assembler bits [8k+7:8k]; byte_cnt increments mod 4.
  - On the accepted byte with byte_cnt==3, the next cycle has:
    - imem_we=1;
    - imem_addr = word_cnt*4;
    - imem_wdata = assembled word;
    - word_cnt incremented.
  - byte_ready stays 1 during the write cycle, so back-to-back bytes are sustained at 1 byte/cycle; the assembler is free for the next word.
  - If the completing word is word len-1, go to FLUSH.
  - byte_valid gaps are tolerated; state is held.
- FLUSH:
  - Entered the cycle imem_we for the last word is high.
  - trigger=1, byte_ready=0.
  - Next cycle: go to IDLE, trigger=0, done=1 for one cycle.
  - Timing: last byte accepted at cycle N; write at N+1; trigger falls and done pulses at N+2.
- abort:
  - In LOAD: go to IDLE next cycle with trigger=0, byte_ready=0.
  - The partial word is discarded; words already written stay written; no done.
  - abort in the same cycle as the final byte: abort wins, no write, no done.
  - abort in FLUSH or IDLE is ignored.
- start is ignored in LOAD and FLUSH.
- imem_we is never high outside the cycle after a 4th accepted byte.
- imem_addr/imem_wdata hold their last values when imem_we=0.
- No address wrap: len_words maximum equals capacity, so word_cnt*4 < 2^ADDR_WIDTH.

Test Plan:
- Reset, then start with len_words=2; stream 13 00 50 00, then 93 00 A0 00 back-to-back:
  - imem_we pulses with addr 0x000 data 0x00500013, then addr 0x004 data 0x00A00093;
  - trigger high from the cycle after start until the cycle done pulses (2 cycles after the 8th byte).
- len_words=1 with byte_valid toggling every other cycle:
  - exactly one write, data assembled correctly, no spurious imem_we during gaps.
- start with len_words=0:
  - done pulses one cycle later, trigger and imem_we never assert.
- len_words=3, abort asserted together with byte 6:
  - only addr 0x000 written, trigger drops next cycle, no done;
  - a subsequent start reloads from addr 0x000.
- rst asserted after 2 bytes of word 0:
  - all outputs return to reset values next cycle, no write.
- start pulsed again during LOAD:
  - ignored, counters and length unchanged, load completes with the original len_words.
